// File: rtl/mmio_seg_io.sv
// rtl/mmio_seg_io.sv - memory-mapped multiplexed 7-segment display and debounced switch peripheral
`timescale 1ns/1ps
module mmio_seg_io #(
    parameter int NDIGITS       = 4,
    parameter int SEGW          = 7,
    parameter int REFRESH_BITS  = 14,
    parameter int NSW           = 2,
    parameter int DEBOUNCE_BITS = 16,
    parameter int BLINK_BITS    = 22
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [3:0]         IOAddr,
    input  logic [31:0]        IOWriteData,
    input  logic               IOWriteEn,
    output logic [31:0]        IOReadData,
    input  logic [NSW-1:0]     SW,
    output logic [SEGW-1:0]    SEG,
    output logic [NDIGITS-1:0] AN
);
    localparam int DW   = NDIGITS * SEGW;
    localparam int IDXW = $clog2(NDIGITS);

    localparam logic [3:0] A_DISP   = 4'h0;
    localparam logic [3:0] A_CTRL   = 4'h1;
    localparam logic [3:0] A_SWITCH = 4'h4;
    localparam logic [3:0] A_CHANGE = 4'h5;

    logic [DW-1:0]            disp_q;
    logic [1:0]               ctrl_q;
    logic [REFRESH_BITS-1:0]  presc_q;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic [BLINK_BITS-1:0]    blink_q;
    logic [NDIGITS-1:0]       an_q, an_d;
    logic [SEGW-1:0]          seg_q, seg_d;
    logic                     blank;

    logic [NSW-1:0]           sync1_q, sync2_q;
    logic [NSW-1:0]           deb_q, deb_d;
    logic [NSW-1:0]           chg_q, chg_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q [NSW];
    logic [DEBOUNCE_BITS-1:0] cnt_d [NSW];

    logic wr_disp, wr_ctrl, wr_chg;
    logic unused_wdata;

    assign wr_disp = IOWriteEn && (IOAddr == A_DISP);
    assign wr_ctrl = IOWriteEn && (IOAddr == A_CTRL);
    assign wr_chg  = IOWriteEn && (IOAddr == A_CHANGE);
    assign unused_wdata = ^IOWriteData;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            disp_q <= '0;
            ctrl_q <= 2'b01;
        end else begin
            if (wr_disp) disp_q <= IOWriteData[DW-1:0];
            if (wr_ctrl) ctrl_q <= IOWriteData[1:0];
        end
    end

    // Digit advances on the cycle the prescaler rolls over to zero.
    always_comb begin
        idx_d = idx_q;
        if (presc_q == '1) begin
            idx_d = (idx_q == IDXW'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    assign blank = !ctrl_q[0] || (ctrl_q[1] && blink_q[BLINK_BITS-1]);

    always_comb begin
        an_d  = '1;
        seg_d = '1;
        if (!blank) begin
            for (int i = 0; i < NDIGITS; i++) begin
                if (idx_q == IDXW'(i)) begin
                    an_d[i] = 1'b0;
                    seg_d   = ~disp_q[i*SEGW +: SEGW];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc_q <= '0;
            idx_q   <= '0;
            blink_q <= '0;
            an_q    <= '1;
            seg_q   <= '1;
        end else begin
            presc_q <= presc_q + 1'b1;
            idx_q   <= idx_d;
            blink_q <= blink_q + 1'b1;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    // A debounce acceptance sets its flag after the W1C clear, so a same-cycle set wins.
    always_comb begin
        deb_d = deb_q;
        chg_d = chg_q;
        if (wr_chg) chg_d = chg_q & ~IOWriteData[NSW-1:0];
        for (int k = 0; k < NSW; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == '1) begin
                    deb_d[k] = sync2_q[k];
                    chg_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            chg_q   <= '0;
            for (int k = 0; k < NSW; k++) cnt_q[k] <= '0;
        end else begin
            sync1_q <= SW;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            chg_q   <= chg_d;
            for (int k = 0; k < NSW; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    always_comb begin
        IOReadData = '0;
        case (IOAddr)
            A_DISP:   IOReadData[DW-1:0]  = disp_q;
            A_CTRL:   IOReadData[1:0]     = ctrl_q;
            A_SWITCH: IOReadData[NSW-1:0] = deb_q;
            A_CHANGE: IOReadData[NSW-1:0] = chg_q;
            default:  IOReadData = '0;
        endcase
    end

    assign SEG = seg_q;
    assign AN  = an_q;

endmodule

// File: tb/tb_mmio_seg_io.sv
// tb/tb_mmio_seg_io.sv - self-checking bench for mmio_seg_io with a cycle-count reference model
`timescale 1ns/1ps
module tb_mmio_seg_io;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  IOAddr = 4'h0;
    logic [31:0] IOWriteData = 32'h0;
    logic        IOWriteEn = 1'b0;
    logic [31:0] IOReadData;
    logic [1:0]  SW = 2'b00;
    logic [6:0]  SEG;
    logic [3:0]  AN;

    mmio_seg_io #(
        .NDIGITS(4), .SEGW(7), .REFRESH_BITS(2), .NSW(2), .DEBOUNCE_BITS(3), .BLINK_BITS(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .IOAddr(IOAddr), .IOWriteData(IOWriteData),
        .IOWriteEn(IOWriteEn), .IOReadData(IOReadData), .SW(SW), .SEG(SEG), .AN(AN)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: time since reset, written registers, and a raw-switch sample window.
    int unsigned m_n;
    int          m_idx;
    logic        m_blank, m_run;
    logic [27:0] m_disp;
    logic [1:0]  m_ctrl, m_deb, m_chg, m_set;
    logic [1:0]  m_h [0:8];
    logic [3:0]  e_an;
    logic [6:0]  e_seg;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_n = 0; m_disp = '0; m_ctrl = 2'b01; m_deb = '0; m_chg = '0;
            e_an = 4'hF; e_seg = 7'h7F;
            for (int j = 0; j < 9; j++) m_h[j] = '0;
        end else begin
            m_idx   = (m_n / 4) % 4;
            m_blank = !m_ctrl[0] || (m_ctrl[1] && ((m_n % 16) >= 8));
            e_an    = m_blank ? 4'hF : ~(4'b0001 << m_idx);
            e_seg   = m_blank ? 7'h7F : ~m_disp[m_idx*7 +: 7];
            m_set = '0;
            for (int k = 0; k < 2; k++) begin
                m_run = 1'b1;
                for (int j = 1; j <= 8; j++) if (m_h[j][k] == m_deb[k]) m_run = 1'b0;
                if (m_run) begin
                    m_deb[k] = ~m_deb[k];
                    m_set[k] = 1'b1;
                end
            end
            if (IOWriteEn) begin
                case (IOAddr)
                    4'h0: m_disp = IOWriteData[27:0];
                    4'h1: m_ctrl = IOWriteData[1:0];
                    4'h5: m_chg  = m_chg & ~IOWriteData[1:0];
                    default: ;
                endcase
            end
            m_chg = m_chg | m_set;
            for (int j = 8; j > 0; j--) m_h[j] = m_h[j-1];
            m_h[0] = SW;
            m_n++;
        end
    end

    function automatic logic [31:0] model_rd(input logic [3:0] a);
        case (a)
            4'h0: return {4'h0, m_disp};
            4'h1: return {30'h0, m_ctrl};
            4'h4: return {30'h0, m_deb};
            4'h5: return {30'h0, m_chg};
            default: return 32'h0;
        endcase
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
        check("AN", {28'h0, AN}, {28'h0, e_an});
        check("SEG", {25'h0, SEG}, {25'h0, e_seg});
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        IOAddr = a; IOWriteData = d; IOWriteEn = 1'b1;
        cyc();
        IOWriteEn = 1'b0;
    endtask

    task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
        IOAddr = a;
        #1;
        check(name, IOReadData, exp);
    endtask

    task automatic do_reset();
        RESET = 1'b1; IOWriteEn = 1'b0; SW = 2'b00;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t       vt [10];
    logic [3:0] an_seq [4];
    int         lit, waited;
    logic [3:0] ra;

    initial begin
        vt[0] = '{4'h0, 32'hFFFF_FFFF, 4'h0, 32'h0FFF_FFFF};
        vt[1] = '{4'h1, 32'h0000_00FF, 4'h1, 32'h0000_0003};
        vt[2] = '{4'h7, 32'hFFFF_FFFF, 4'h7, 32'h0000_0000};
        vt[3] = '{4'h7, 32'h1234_5678, 4'h0, 32'h0FFF_FFFF};
        vt[4] = '{4'h4, 32'h0000_0003, 4'h4, 32'h0000_0000};
        vt[5] = '{4'h5, 32'h0000_0003, 4'h5, 32'h0000_0000};
        vt[6] = '{4'h1, 32'h0000_0001, 4'h1, 32'h0000_0001};
        vt[7] = '{4'h0, 32'h0020_4081, 4'h0, 32'h0020_4081};
        vt[8] = '{4'h9, 32'h0000_AAAA, 4'hF, 32'h0000_0000};
        vt[9] = '{4'h1, 32'h0000_0002, 4'h1, 32'h0000_0002};
        an_seq[0] = 4'hE; an_seq[1] = 4'hD; an_seq[2] = 4'hB; an_seq[3] = 4'h7;

        do_reset();
        check("rst_AN", {28'h0, AN}, 32'hF);
        check("rst_SEG", {25'h0, SEG}, 32'h7F);
        rd("rst_DISP", 4'h0, 32'h0);
        rd("rst_CTRL", 4'h1, 32'h1);
        rd("rst_SWITCH", 4'h4, 32'h0);
        rd("rst_CHANGE", 4'h5, 32'h0);

        for (int i = 0; i < 10; i++) begin
            wr(vt[i].wa, vt[i].wd);
            rd($sformatf("vec%0d", i), vt[i].ra, vt[i].exp);
        end

        do_reset();
        wr(4'h0, 32'h0020_4081);
        check("refresh_first_AN", {28'h0, AN}, 32'hE);
        for (int n = 2; n <= 17; n++) begin
            cyc();
            check($sformatf("refresh_AN_%0d", n), {28'h0, AN}, {28'h0, an_seq[((n - 1) >> 2) & 3]});
            check($sformatf("refresh_SEG_%0d", n), {25'h0, SEG}, 32'h7E);
        end

        SW = 2'b01;
        repeat (9) cyc();
        rd("deb_early", 4'h4, 32'h0);
        cyc();
        rd("deb_switch", 4'h4, 32'h1);
        rd("deb_change", 4'h5, 32'h1);
        SW = 2'b11;
        repeat (5) cyc();
        SW = 2'b01;
        repeat (12) cyc();
        rd("glitch_switch", 4'h4, 32'h1);
        rd("glitch_change", 4'h5, 32'h1);

        wr(4'h5, 32'h3);
        rd("w1c_clear", 4'h5, 32'h0);
        SW = 2'b00;
        repeat (9) cyc();
        IOAddr = 4'h5; IOWriteData = 32'h1; IOWriteEn = 1'b1;
        cyc();
        IOWriteEn = 1'b0;
        rd("collide_change", 4'h5, 32'h1);
        rd("collide_switch", 4'h4, 32'h0);
        wr(4'h5, 32'h1);
        rd("w1c_later", 4'h5, 32'h0);

        wr(4'h1, 32'h0);
        cyc();
        check("blank_AN", {28'h0, AN}, 32'hF);
        check("blank_SEG", {25'h0, SEG}, 32'h7F);
        wr(4'h1, 32'h3);
        cyc();
        lit = 0;
        for (int i = 0; i < 32; i++) begin
            cyc();
            if (AN != 4'hF) lit++;
        end
        check("blink_lit_count", lit, 32'd16);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: IOAddr = 4'h0;
                    1: IOAddr = 4'h1;
                    2: IOAddr = 4'h5;
                    3: IOAddr = 4'h4;
                    default: IOAddr = 4'h7;
                endcase
                IOWriteData = $urandom;
                IOWriteEn = 1'b1;
            end
            if ($urandom_range(0, 11) == 0) SW = 2'($urandom);
            cyc();
            IOWriteEn = 1'b0;
            ra = 4'($urandom_range(0, 7));
            rd($sformatf("rand_rd_%0h", ra), ra, model_rd(ra));
        end

        do_reset();
        wr(4'h0, 32'h0123_4567);
        SW = 2'b01;
        repeat (10) cyc();
        rd("pre_rst_change", 4'h5, 32'h1);
        waited = 0;
        while ((m_n % 16) != 8 && waited < 20) begin
            cyc();
            waited++;
        end
        check("idx_wait_in_budget", {31'h0, waited < 20}, 32'h1);
        SW = 2'b11;
        repeat (2) cyc();
        check("pre_rst_AN", {28'h0, AN}, 32'hB);
        #3;
        RESET = 1'b1;
        #1;
        check("midrst_AN", {28'h0, AN}, 32'hF);
        check("midrst_SEG", {25'h0, SEG}, 32'h7F);
        rd("midrst_DISP", 4'h0, 32'h0);
        rd("midrst_CTRL", 4'h1, 32'h1);
        rd("midrst_CHANGE", 4'h5, 32'h0);
        rd("midrst_SWITCH", 4'h4, 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        repeat (9) cyc();
        rd("post_rst_early", 4'h4, 32'h0);
        cyc();
        rd("post_rst_switch", 4'h4, 32'h3);
        rd("post_rst_change", 4'h5, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mmio_seg_io.md
Name: mmio_seg_io

Overview:
Parametrised memory-mapped I/O peripheral between the MIPS core's IO bus and the board's multiplexed 7-segment display and switches.
- Holds per-digit segment patterns and drives time-multiplexed, active-low anode/segment outputs, with optional blanking and blink.
- Synchronises and debounces NSW switch inputs.
- Keeps sticky per-switch change flags, readable by software and cleared by write-1-to-clear.

Parameters:
NDIGITS, 4, number of display digits (2..4); NDIGITS*SEGW must be <= 32
SEGW, 7, segment bits per digit
REFRESH_BITS, 14, each digit stays lit for 2^REFRESH_BITS cycles
NSW, 2, number of switch inputs (1..16)
DEBOUNCE_BITS, 16, a switch must hold a new value for 2^DEBOUNCE_BITS consecutive cycles before it is accepted
BLINK_BITS, 22, blink period is 2^BLINK_BITS cycles, 50% duty

Ports:
CLK  in  1  system clock (10 MHz)
RESET  in  1  reset, asynchronous, active-high
IOAddr  in  4  IO word address
IOWriteData  in  32  write data
IOWriteEn  in  1  write strobe, sampled on the CLK rising edge
IOReadData  out  32  read data, combinational from IOAddr
SW  in  NSW  raw asynchronous switch inputs
SEG  out  SEGW  segment drive, active-low, registered
AN  out  NDIGITS  anode select, active-low one-hot, registered

Behaviour:
Register map (all other addresses read 0; writes to them are ignored):
- 0x0 DISP (RW): bits [NDIGITS*SEGW-1:0]. Digit i = bits [i*SEGW+SEGW-1 : i*SEGW]. Upper bits read 0.
- 0x1 CTRL (RW): bit0 EN (display enable), bit1 BLINK. Other bits read 0.
- 0x4 SWITCH (RO): {zeros, debounced switch values[NSW-1:0]}.
- 0x5 CHANGE (R/W1C): {zeros, sticky change flags[NSW-1:0]}. Writing 1 to bit k clears flag k; writing 0 leaves it unchanged.

Reset values:
- DISP = 0; CTRL = 0x1.
- Refresh prescaler = 0; digit index = 0; blink counter = 0.
- Sync flops = 0; debounced values = 0; debounce counters = 0; CHANGE = 0.
- AN = all ones; SEG = all ones.
- RESET asserted mid-operation returns everything to these values immediately. There is no partial state.

Register writes:
- Take effect on the CLK edge where IOWriteEn = 1.
- The new value is visible on IOReadData in the next cycle.

Refresh:
- The REFRESH_BITS-bit prescaler free-runs.
- When it wraps to 0, the digit index increments; NDIGITS-1 wraps to 0.
- Registered outputs, one cycle after the digit index changes: AN = ~(1 << index); SEG = ~DISP digit[index].
- A DISP write appears on SEG within one cycle if that digit is currently selected.

Blanking:
- When EN = 0, or when BLINK = 1 and the blink counter MSB = 1: AN = all ones and SEG = all ones (registered, one cycle latency).
- Counters keep running while blanked.

Debounce, per switch k:
- Two-flop synchroniser feeds sync[k].
- If sync[k] == deb[k], the counter clears.
- Otherwise the counter increments. When it reaches 2^DEBOUNCE_BITS-1 with sync[k] still different:
  - deb[k] <= sync[k];
  - counter clears;
  - CHANGE[k] is set.
- Latency from a stable raw edge to the SWITCH update: 2 + 2^DEBOUNCE_BITS cycles.
- A glitch shorter than the threshold causes no update.

CHANGE set/clear collision: if a set and a W1C clear hit the same bit in the same cycle, the set wins and the flag stays 1.

Test Plan:
Use NDIGITS=4, SEGW=7, REFRESH_BITS=2, DEBOUNCE_BITS=3, BLINK_BITS=4.
1. Reset and refresh: release RESET, write DISP=0x0204081 -> AN steps through 1110, 1101, 1011, 0111, each for 4 cycles. SEG = ~0x01, ~0x01, ~0x01, ~0x01 (every 7-bit field is 0x01). Before the first update, AN = 1111 and SEG = 1111111.
2. Readback: write DISP=0xFFFFFFFF -> reads 0x0FFFFFFF. Write CTRL=0xFF -> reads 0x3. Read 0x7 -> 0. Write 0x7 -> no state change.
3. Debounce: hold SW=2'b01 -> SWITCH reads 0x1 exactly 10 cycles after the edge and CHANGE = 0x1. A 5-cycle pulse on SW[1] -> SWITCH unchanged, CHANGE[1] = 0.
4. W1C collision: write CHANGE=0x1 in the same cycle that SW[0] toggles its debounced value -> CHANGE[0] remains 1. Writing 0x1 on a later cycle -> 0.
5. Blank/blink: write CTRL=0 -> AN = 1111 next cycle. Write CTRL=0x3 -> display alternates lit/blank every 8 cycles.
6. Mid-operation reset: assert RESET asynchronously while digit index = 2 and a debounce count is pending -> AN = 1111 immediately, CHANGE = 0, DISP = 0, CTRL = 1.
